seq_det_moore_param: RTL

//  Parametrised Moore serial pattern detector; successor to the fixed 3-bit detectors.

---
 rtl/seq_det_moore_param_if.sv | 55 +++++
 rtl/seq_det_moore_param.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/seq_det_moore_param_if.sv
// -----------------------------------------------------------------------------
// seq_det_moore_param_if
//   Signal bundle for the parametrised Moore serial pattern detector.
//   The block that feeds the stream uses the master modport; the detector
//   itself uses the slave modport. Clock and reset are not part of the bundle.
//
// Parameters
//   PAT_W      pattern length in bits (>= 2)
//   CNT_W      match counter width
//
// Signals (direction seen from the detector / slave side)
//   din_valid  in   1      din is sampled only when 1
//   din        in   1      serial data bit
//   overlap    in   1      1 = overlapping detection, 0 = non-overlapping
//   pat_wr     in   1      load pat_in into the pattern register
//   pat_in     in   PAT_W  new pattern, MSB = first bit received
//   cnt_clr    in   1      clear match_cnt
//   dout       out  1      match flag
//   match_cnt  out  CNT_W  saturating match count
// -----------------------------------------------------------------------------
interface seq_det_moore_param_if #(
    parameter int PAT_W = 3,
    parameter int CNT_W = 8
);
    logic             din_valid;
    logic             din;
    logic             overlap;
    logic             pat_wr;
    logic [PAT_W-1:0] pat_in;
    logic             cnt_clr;
    logic             dout;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output din_valid,
        output din,
        output overlap,
        output pat_wr,
        output pat_in,
        output cnt_clr,
        input  dout,
        input  match_cnt
    );

    modport slave (
        input  din_valid,
        input  din,
        input  overlap,
        input  pat_wr,
        input  pat_in,
        input  cnt_clr,
        output dout,
        output match_cnt
    );
endinterface

// File: rtl/seq_det_moore_param.sv
// -----------------------------------------------------------------------------
// seq_det_moore_param
//   Parametrised Moore serial pattern detector. Bits are accepted when
//   din_valid is high and shifted into a history register; once PAT_W bits
//   have been collected since the last restart, a history equal to the
//   pattern register moves the FSM to S_MATCH and dout goes high one clock
//   after the completing bit. The pattern can be reloaded at run time.
//   Overlapping and non-overlapping detection are selected per accepted bit.
//
// Configuration
//   DET_MATCH_CNT_EN  when defined, a saturating match counter is built;
//                     otherwise match_cnt is tied to 0 and cnt_clr is unused.
//                     Ports are identical in both builds.
//
// Parameters
//   PAT_W    pattern length in bits (>= 2)
//   PATTERN  pattern loaded at reset, MSB = first bit received
//   CNT_W    match counter width
//
// Ports
//   clk      in     rising-edge clock
//   reset    in     synchronous, active-high reset; overrides every input
//   bus      slave  seq_det_moore_param_if (stream, pattern load, outputs)
// -----------------------------------------------------------------------------
module seq_det_moore_param #(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PATTERN = 3'b011,
    parameter int               CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    seq_det_moore_param_if.slave  bus
);

    // fill counts 0..PAT_W, so it needs one value more than PAT_W bits index.
    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,   // history not yet full
        S_HUNT  = 2'd1,   // history full, no match
        S_MATCH = 2'd2    // match seen on the last accepted bit
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [PAT_W-1:0]   pat_reg;
    logic [PAT_W-1:0]   hist;
    logic [PAT_W-1:0]   hist_n;
    logic [FILL_W-1:0]  fill;
    logic [FILL_W-1:0]  fill_n;
    logic [FILL_W-1:0]  fill_inc;
    logic               dout_q;

    // -------------------------------------------------------------------------
    // Next-state decode
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block so no path
    // leaves one unassigned; a missing default would infer a latch.
    always_comb begin
        hist_n   = hist;
        fill_n   = fill;
        state_n  = state;
        fill_inc = (fill == FILL_FULL) ? fill : fill + 1'b1;

        if (bus.pat_wr) begin
            // Pattern load restarts collection; a same-cycle din bit is dropped.
            fill_n  = '0;
            state_n = S_FILL;
        end else if (bus.din_valid) begin
            hist_n = {hist[PAT_W-2:0], bus.din};
            fill_n = fill_inc;
            if ((fill_inc == FILL_FULL) && (hist_n == pat_reg)) begin
                state_n = S_MATCH;
                // Non-overlapping: the next match must be built from PAT_W
                // fresh bits, so collection restarts from empty.
                if (!bus.overlap) begin
                    fill_n = '0;
                end
            end else if (fill_inc == FILL_FULL) begin
                state_n = S_HUNT;
            end else begin
                state_n = S_FILL;
            end
        end else begin
            // Idle cycle: history holds; a match flag lasts only one cycle.
            unique case (state)
                S_MATCH: state_n = (fill == '0) ? S_FILL : S_HUNT;
                S_FILL:  state_n = S_FILL;
                S_HUNT:  state_n = S_HUNT;
                default: state_n = S_FILL;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM and datapath registers; dout is registered from the next state so
    // it reflects exactly state == S_MATCH without a decode after the flop.
    // -------------------------------------------------------------------------
    // NOTE: state is written with non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pat_reg <= PATTERN;
            hist    <= '0;
            fill    <= '0;
            state   <= S_FILL;
            dout_q  <= 1'b0;
        end else begin
            if (bus.pat_wr) begin
                pat_reg <= bus.pat_in;
            end
            hist   <= hist_n;
            fill   <= fill_n;
            state  <= state_n;
            dout_q <= (state_n == S_MATCH);
        end
    end

    assign bus.dout = dout_q;

    // -------------------------------------------------------------------------
    // Optional saturating match counter
    // -------------------------------------------------------------------------
`ifdef DET_MATCH_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;

    // Counts every edge that loads S_MATCH; clear wins over a same-cycle hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (bus.cnt_clr) begin
            cnt_q <= '0;
        end else if ((state_n == S_MATCH) && (cnt_q != CNT_MAX)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.match_cnt = cnt_q;
`else
    // No counter in this build: output tied low, clear input deliberately unused.
    logic unused_cnt_clr;
    assign unused_cnt_clr = bus.cnt_clr;
    assign bus.match_cnt  = '0;
`endif

endmodule
